// File: rtl/beat_timer.sv
// Beat timing generator for the hardwired controller: emits the one-hot
// W1/W2/W3 beat, tracks run/halt state from a debounced console start,
// single-step mode and controller STOP, and counts instruction cycles.
module beat_timer #(
   parameter int DEBOUNCE_CYCLES = 2,
   parameter int CNT_W           = 8
) (
   input  logic             T3,
   input  logic             CLR,
   input  logic             QD,
   input  logic             DP,
   input  logic             SHORT,
   input  logic             LONG,
   input  logic             STOP,
   output logic [3:1]       W,
   output logic             RUN,
   output logic             CYC_DONE,
   output logic [CNT_W-1:0] INSTR_CNT
);

   localparam int               DEB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

   // Beat state is stored directly in its one-hot output encoding.
   typedef enum logic [2:0] {
      BEAT_W1 = 3'b001,
      BEAT_W2 = 3'b010,
      BEAT_W3 = 3'b100
   } beat_t;

   beat_t              beat_q, beat_d;
   logic               run_q, run_d;
   logic               armed_q, armed_d;
   logic [DEB_W-1:0]   deb_q, deb_d;
   logic               done_q;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               cyc_end;

   // State register; CLR overrides every other input.
   always_ff @(posedge T3) begin
      if (CLR) begin
         beat_q  <= BEAT_W1;
         run_q   <= 1'b0;
         armed_q <= 1'b0;
         deb_q   <= '0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         beat_q  <= beat_d;
         run_q   <= run_d;
         armed_q <= armed_d;
         deb_q   <= deb_d;
         done_q  <= cyc_end;
         cnt_q   <= cnt_d;
      end
   end

   // Beat sequencing: advances only while running; illegal codes fall back to W1.
   always_comb begin
      beat_d  = beat_q;
      cyc_end = 1'b0;
      case (beat_q)
         BEAT_W1: begin
            if (run_q) begin
               if (SHORT) cyc_end = 1'b1;
               else       beat_d  = BEAT_W2;
            end
         end
         BEAT_W2: begin
            if (run_q) begin
               if (LONG) begin
                  beat_d = BEAT_W3;
               end else begin
                  beat_d  = BEAT_W1;
                  cyc_end = 1'b1;
               end
            end
         end
         BEAT_W3: begin
            if (run_q) begin
               beat_d  = BEAT_W1;
               cyc_end = 1'b1;
            end
         end
         default: beat_d = BEAT_W1;
      endcase
   end

   // Run/halt control: debounced start while halted, STOP and single-step halts.
   always_comb begin
      run_d   = run_q;
      armed_d = armed_q;
      deb_d   = '0;
      if (run_q && (STOP || (DP && cyc_end))) begin
         run_d = 1'b0;
      end
      // A low sample always re-arms and clears the debounce count; high
      // samples only count while halted and armed, so a held button
      // never retriggers.
      if (!QD) begin
         armed_d = 1'b1;
      end else if (!run_q && armed_q) begin
         if (deb_q == DEB_LAST) begin
            run_d   = 1'b1;
            armed_d = 1'b0;
         end else begin
            deb_d = deb_q + DEB_W'(1);
         end
      end
   end

   // Instruction-cycle counter, wraps naturally at 2^CNT_W.
   always_comb begin
      cnt_d = cnt_q;
      if (cyc_end) cnt_d = cnt_q + CNT_W'(1);
   end

   assign W         = beat_q;
   assign RUN       = run_q;
   assign CYC_DONE  = done_q;
   assign INSTR_CNT = cnt_q;

endmodule

// File: tb/tb_beat_timer.sv
// Scoreboard bench for beat_timer: a driver applies directed and random
// stimulus, predicts the post-edge outputs with a beat-number model and
// queues them; a monitor pops and compares after every rising edge.
module tb_beat_timer;

   localparam int DEB   = 2;
   localparam int CW    = 8;

   logic          T3 = 1'b0;
   logic          CLR = 1'b1;
   logic          QD = 1'b0, DP = 1'b0, SHORT = 1'b0, LONG = 1'b0, STOP = 1'b0;
   logic [3:1]    W;
   logic          RUN;
   logic          CYC_DONE;
   logic [CW-1:0] INSTR_CNT;

   beat_timer #(.DEBOUNCE_CYCLES(DEB), .CNT_W(CW)) dut (
      .T3(T3), .CLR(CLR), .QD(QD), .DP(DP), .SHORT(SHORT), .LONG(LONG),
      .STOP(STOP), .W(W), .RUN(RUN), .CYC_DONE(CYC_DONE), .INSTR_CNT(INSTR_CNT)
   );

   always #5 T3 = ~T3;

   typedef struct packed {
      logic [2:0]    w;
      logic          run;
      logic          done;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk  = 0;
   int   n_fail = 0;
   bit   drv_done = 0;

   // Reference model: beat number 1..3, run flag, armed flag, consecutive-high count.
   int m_beat = 1;
   bit m_run = 0, m_armed = 0, m_done = 0;
   int m_hi = 0, m_cnt = 0;

   task automatic step(input bit clr, input bit qd, input bit dp,
                       input bit s, input bit l, input bit stop);
      exp_t e;
      bit   end_c;
      bit   nrun;
      CLR = clr; QD = qd; DP = dp; SHORT = s; LONG = l; STOP = stop;
      if (clr) begin
         m_beat = 1; m_run = 0; m_armed = 0; m_hi = 0; m_cnt = 0; m_done = 0;
      end else begin
         end_c = 0;
         nrun  = m_run;
         if (m_run) begin
            if (m_beat == 1) begin
               if (s) end_c = 1; else m_beat = 2;
            end else if (m_beat == 2) begin
               if (l) m_beat = 3; else begin m_beat = 1; end_c = 1; end
            end else begin
               m_beat = 1; end_c = 1;
            end
            if (end_c) m_cnt = (m_cnt + 1) % (1 << CW);
            if (stop || (dp && end_c)) nrun = 0;
         end
         if (!qd) begin
            m_armed = 1; m_hi = 0;
         end else if (!m_run && m_armed) begin
            m_hi = m_hi + 1;
            if (m_hi >= DEB) begin nrun = 1; m_armed = 0; m_hi = 0; end
         end else begin
            m_hi = 0;
         end
         m_run  = nrun;
         m_done = end_c;
      end
      e.w    = 3'(1 << (m_beat - 1));
      e.run  = m_run;
      e.done = m_done;
      e.cnt  = CW'(m_cnt);
      exp_q.push_back(e);
      @(negedge T3);
   endtask

   // Monitor: compares the registered outputs just after each rising edge.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge T3);
         #1;
         a = {W, RUN, CYC_DONE, INSTR_CNT};
         if (exp_q.size() == 0) begin
            if (!drv_done) begin
               n_chk++; n_fail++;
               $display("FAIL scoreboard_empty t=%0t no expected entry", $time);
            end
         end else begin
            e = exp_q.pop_front();
            n_chk++;
            if (a !== e) begin
               n_fail++;
               $display("FAIL outputs t=%0t actual W=%b RUN=%b CYC_DONE=%b CNT=%0d required W=%b RUN=%b CYC_DONE=%b CNT=%0d",
                        $time, a.w, a.run, a.done, a.cnt, e.w, e.run, e.done, e.cnt);
            end
         end
      end
   end

   initial begin
      bit qd_r, dp_r;
      // Reset, then idle with QD low.
      step(1,0,0,0,0,0);
      step(0,0,0,0,0,0);
      // One-edge press is rejected; two-edge press starts.
      step(0,1,0,0,0,0);
      step(0,0,0,0,0,0);
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,0);
      // SHORT in W1 three times: W stays W1, count 0->3.
      repeat (3) step(0,1,0,1,0,0);
      // Normal cycle W1,W2,W1 then long cycle W1,W2,W3,W1.
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,0);
      step(0,1,0,0,1,0);
      step(0,1,0,0,0,0);
      // STOP in W2 with QD still held: halt, no restart until low then two highs.
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,1);
      repeat (3) step(0,1,0,1,1,1);
      step(0,0,0,0,0,0);
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,0);
      // Single-step: halts at W1 after each cycle.
      step(0,0,1,0,0,0);
      step(0,0,1,0,0,0);
      step(0,0,1,1,1,0);
      step(0,1,1,0,0,0);
      step(0,1,1,0,0,0);
      step(0,0,1,1,0,0);
      step(0,0,1,0,0,0);
      // Restart and wrap the counter past 255.
      step(0,1,0,0,0,0);
      step(0,1,0,0,0,0);
      repeat (260) step(0,0,0,1,0,0);
      // Reach W3 and reset there.
      step(0,0,0,0,0,0);
      step(0,0,0,0,1,0);
      step(1,1,0,1,1,1);
      step(0,0,0,0,0,0);
      // Randomized phase with held-level QD/DP and occasional reset.
      qd_r = 0; dp_r = 0;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 5) == 0)  qd_r = ~qd_r;
         if ($urandom_range(0, 40) == 0) dp_r = ~dp_r;
         step($urandom_range(0, 99) == 0, qd_r, dp_r,
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(0, 19) == 0);
      end
      drv_done = 1;
      @(posedge T3);
      #2;
      n_chk++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain actual %0d pending required 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
